// File: rtl/wb_stage.sv
//------------------------------------------------------------------------------
// Module   : wb_stage
// Brief    : MEM/WB pipeline register, write-back select, sticky halt FSM and
//            saturating retired-instruction counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [1:0]        mem_wb_sel,
  input  logic [DATA_W-1:0] mem_alu_res,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic [DATA_W-1:0] mem_link,
  input  logic [DATA_W-1:0] mem_imm,
  input  logic              mem_halt,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              halted,
  output logic [CNT_W-1:0]  retire_cnt
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_cntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic                r_wbValid;
  logic                r_wbRegWrite;
  logic                r_wbHalt;
  logic [ADDR_W-1:0]   r_wbRd;
  logic [1:0]          r_wbSel;
  logic [DATA_W-1:0]   r_wbAlu;
  logic [DATA_W-1:0]   r_wbRdData;
  logic [DATA_W-1:0]   r_wbLink;
  logic [DATA_W-1:0]   r_wbImm;
  logic [CNT_W-1:0]    r_retireCnt;

  logic                w_run;
  logic                w_retire;
  logic [DATA_W-1:0]   w_wdata;

  assign w_run    = (r_state == RUN);
  assign w_retire = r_wbValid & ~stall & w_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RUN;
      r_wbValid    <= 1'b0;
      r_wbRegWrite <= 1'b0;
      r_wbHalt     <= 1'b0;
      r_wbRd       <= '0;
      r_wbSel      <= '0;
      r_wbAlu      <= '0;
      r_wbRdData   <= '0;
      r_wbLink     <= '0;
      r_wbImm      <= '0;
      r_retireCnt  <= '0;
    end else if (w_run) begin
      // A HALT already in WB retires even when the incoming entry is flushed.
      if (w_retire && r_wbHalt) begin
        r_state <= HALTED;
      end
      if (w_retire && (r_retireCnt != {CNT_W{1'b1}})) begin
        r_retireCnt <= r_retireCnt + c_cntOne;
      end
      if (flush) begin
        r_wbValid    <= 1'b0;
        r_wbRegWrite <= 1'b0;
        r_wbHalt     <= 1'b0;
        r_wbRd       <= '0;
        r_wbSel      <= '0;
        r_wbAlu      <= '0;
        r_wbRdData   <= '0;
        r_wbLink     <= '0;
        r_wbImm      <= '0;
      end else if (!stall) begin
        r_wbValid    <= mem_valid;
        r_wbRegWrite <= mem_reg_write;
        r_wbHalt     <= mem_halt;
        r_wbRd       <= mem_rd;
        r_wbSel      <= mem_wb_sel;
        r_wbAlu      <= mem_alu_res;
        r_wbRdData   <= mem_rd_data;
        r_wbLink     <= mem_link;
        r_wbImm      <= mem_imm;
      end
    end
  end

  always_comb begin
    w_wdata = r_wbAlu;
    case (r_wbSel)
      2'd0:    w_wdata = r_wbAlu;
      2'd1:    w_wdata = r_wbRdData;
      2'd2:    w_wdata = r_wbLink;
      default: w_wdata = r_wbImm;
    endcase
  end

  // r0 is hardwired zero, so writes to it never reach the register file.
  assign rf_we      = r_wbValid & r_wbRegWrite & ~r_wbHalt & (r_wbRd != '0) & ~stall & w_run;
  assign rf_waddr   = r_wbRd;
  assign rf_wdata   = w_wdata;
  assign halted     = (r_state == HALTED);
  assign retire_cnt = r_retireCnt;

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_wb_stage
// Brief    : Self-checking bench for wb_stage: directed scenarios plus random
//            traffic compared against a behavioural pipeline-slot model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_stage;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int CW = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, flush;
  logic          mem_valid, mem_reg_write, mem_halt;
  logic [AW-1:0] mem_rd;
  logic [1:0]    mem_wb_sel;
  logic [DW-1:0] mem_alu_res, mem_rd_data, mem_link, mem_imm;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          halted;
  logic [CW-1:0] retire_cnt;

  always #5 clk = ~clk;

  wb_stage #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_wb_sel(mem_wb_sel), .mem_alu_res(mem_alu_res), .mem_rd_data(mem_rd_data),
    .mem_link(mem_link), .mem_imm(mem_imm), .mem_halt(mem_halt),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .halted(halted), .retire_cnt(retire_cnt)
  );

  // Model: the instruction sitting in WB, whether the machine stopped, and how many retired.
  typedef struct packed {
    bit          v;
    bit          rw;
    bit [AW-1:0] rd;
    bit [1:0]    sel;
    bit [DW-1:0] alu;
    bit [DW-1:0] ld;
    bit [DW-1:0] lnk;
    bit [DW-1:0] imm;
    bit          hlt;
  } entry_t;

  entry_t mSlot;
  bit     mHalted;
  int     mCount;
  int     checks   = 0;
  int     failures = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    mSlot   = '0;
    mHalted = 1'b0;
    mCount  = 0;
  endtask

  task automatic checkOutputs(input string tag);
    bit          expWe;
    bit [DW-1:0] expData;
    expWe = mSlot.v && mSlot.rw && !mSlot.hlt && (mSlot.rd != 0) && !stall && !mHalted;
    case (mSlot.sel)
      2'd0: expData = mSlot.alu;
      2'd1: expData = mSlot.ld;
      2'd2: expData = mSlot.lnk;
      default: expData = mSlot.imm;
    endcase
    checkVal({tag, ".we"},     32'(rf_we),      32'(expWe));
    checkVal({tag, ".waddr"},  32'(rf_waddr),   32'(mSlot.rd));
    checkVal({tag, ".wdata"},  32'(rf_wdata),   32'(expData));
    checkVal({tag, ".halted"}, 32'(halted),     32'(mHalted));
    checkVal({tag, ".cnt"},    32'(retire_cnt), 32'(mCount));
  endtask

  task automatic modelStep();
    entry_t inSlot;
    inSlot = '{v: mem_valid, rw: mem_reg_write, rd: mem_rd, sel: mem_wb_sel,
               alu: mem_alu_res, ld: mem_rd_data, lnk: mem_link, imm: mem_imm,
               hlt: mem_halt};
    if (!mHalted) begin
      if (mSlot.v && !stall) begin
        if (mCount < CNT_MAX) mCount++;
        if (mSlot.hlt) mHalted = 1'b1;
      end
      if (flush)       mSlot = '0;
      else if (!stall) mSlot = inSlot;
    end
  endtask

  task automatic drive(input bit v, input bit rw, input int rd, input int sel,
                       input int data, input bit hlt, input bit st, input bit fl);
    mem_valid     = v;
    mem_reg_write = rw;
    mem_rd        = AW'(rd);
    mem_wb_sel    = 2'(sel);
    mem_alu_res   = (sel == 0) ? DW'(data) : DW'($urandom);
    mem_rd_data   = (sel == 1) ? DW'(data) : DW'($urandom);
    mem_link      = (sel == 2) ? DW'(data) : DW'($urandom);
    mem_imm       = (sel == 3) ? DW'(data) : DW'($urandom);
    mem_halt      = hlt;
    stall         = st;
    flush         = fl;
  endtask

  task automatic driveRandom(input bit allowHalt);
    drive(($urandom % 4) != 0, $urandom % 2, $urandom % 16, $urandom % 4, $urandom,
          allowHalt && (($urandom % 32) == 0), ($urandom % 4) == 0, ($urandom % 8) == 0);
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    checkOutputs(tag);
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic bubble();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bubble();
    modelReset();
    @(negedge clk);
    checkOutputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ALU write to r3, then three back-to-back writes from the other sources
    drive(1, 1, 3, 0, 16'h1234, 0, 0, 0); cycle("alu_cap");
    drive(1, 1, 5, 1, 16'hBEEF, 0, 0, 0); cycle("alu_wb");
    drive(1, 1, 7, 2, 16'h0042, 0, 0, 0); cycle("mem_wb");
    drive(1, 1, 2, 3, 16'hFF80, 0, 0, 0); cycle("link_wb");
    drive(1, 1, 0, 0, 16'h5555, 0, 0, 0); cycle("imm_wb");
    bubble();                              cycle("r0_wb");
    cycle("idle");
    checkVal("cnt_after_five", 32'(retire_cnt), 32'd5);

    // Stall holds a valid instruction for three cycles; one write when it drops
    drive(1, 1, 9, 0, 16'hA5A5, 0, 0, 0); cycle("stall_cap");
    drive(1, 1, 10, 0, 16'h1111, 0, 1, 0);
    for (int i = 0; i < 3; i++) cycle($sformatf("stall%0d", i));
    drive(1, 1, 11, 0, 16'h2222, 0, 0, 0); cycle("stall_drop");
    bubble();                               cycle("stall_next");

    // flush wins over stall: bubble loaded, nothing written, count unchanged
    drive(1, 1, 6, 0, 16'h3333, 0, 1, 1); cycle("flush_stall");
    bubble();                              cycle("flush_after");
    cycle("flush_idle");

    // Random traffic without HALT, running the counter into saturation
    for (int i = 0; i < 200; i++) begin
      driveRandom(1'b0);
      cycle("rand");
    end
    checkVal("cnt_saturated", 32'(retire_cnt), CNT_MAX);

    // HALT in WB alongside a flush: HALT retires and halts; later writes ignored
    rst_n = 1'b0; bubble(); modelReset();
    #2; rst_n = 1'b1;
    drive(1, 1, 4, 0, 16'h4444, 1, 0, 0); cycle("halt_cap");
    drive(1, 1, 8, 0, 16'h7777, 0, 0, 1); cycle("halt_flush");
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1 + i, i, $urandom, 0, i == 2, i == 3);
      cycle($sformatf("halted%0d", i));
    end
    checkVal("halt_sticky", 32'(halted), 32'd1);
    checkVal("halt_cnt", 32'(retire_cnt), 32'd1);

    // Asynchronous reset in mid-cycle clears everything at once
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("arst.halted", 32'(halted),     32'd0);
    checkVal("arst.cnt",    32'(retire_cnt), 32'd0);
    checkVal("arst.we",     32'(rf_we),      32'd0);
    checkVal("arst.waddr",  32'(rf_waddr),   32'd0);
    checkVal("arst.wdata",  32'(rf_wdata),   32'd0);
    modelReset();
    bubble();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic with occasional HALT
    for (int i = 0; i < 150; i++) begin
      driveRandom(1'b1);
      cycle("rand_halt");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
